// File: rtl/adder_1bit_pkg.sv
// Shared constants for the adder_1bit slice.
package adder_1bit_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

endpackage

// File: rtl/adder_1bit_if.sv
// Operand/result bundle for adder_1bit. The master drives operands; the slave is the adder.
interface adder_1bit_if;

    logic a;
    logic b;
    logic c_in;
    logic in_valid;
    logic serial_en;
    logic clear;
    logic sum;
    logic c_out;
    logic sum_q;
    logic c_out_q;
    logic out_valid;
    logic word_last;

    modport master (
        output a, b, c_in, in_valid, serial_en, clear,
        input  sum, c_out, sum_q, c_out_q, out_valid, word_last
    );

    modport slave (
        input  a, b, c_in, in_valid, serial_en, clear,
        output sum, c_out, sum_q, c_out_q, out_valid, word_last
    );

endinterface

// File: rtl/adder_1bit_full_adder_cell.sv
// Purely combinational full-adder cell.
module adder_1bit_full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/adder_1bit.sv
// Full-adder slice with registered outputs and an LSB-first bit-serial mode
// using an internal carry register and bit counter.
import adder_1bit_pkg::*;

module adder_1bit #(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input logic          i_clk,
    input logic          i_rst_n,
    adder_1bit_if.slave  io_bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sum;
    logic             r_cout;
    logic             r_valid;
    logic             r_last;

    logic             w_cin_eff;
    logic             w_sum;
    logic             w_cout;
    logic             w_step;
    logic [CNT_W-1:0] w_bit_idx;
    logic             w_is_last;
    logic             w_carry_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_cin_eff = io_bus.clear ? 1'b0 : (io_bus.serial_en ? r_carry : io_bus.c_in);

    adder_1bit_full_adder_cell u_cell (
        .i_a    (io_bus.a),
        .i_b    (io_bus.b),
        .i_cin  (w_cin_eff),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_step    = io_bus.in_valid & io_bus.serial_en;
    // A clear in the same cycle as a valid bit makes that bit bit 0.
    assign w_bit_idx = io_bus.clear ? '0 : r_cnt;
    assign w_is_last = w_step && (w_bit_idx == LAST_IDX);

    always_comb begin
        w_carry_nxt = r_carry;
        w_cnt_nxt   = r_cnt;
        if (!io_bus.serial_en) begin
            w_carry_nxt = 1'b0;
            w_cnt_nxt   = '0;
        end else if (io_bus.in_valid) begin
            w_carry_nxt = w_is_last ? 1'b0 : w_cout;
            w_cnt_nxt   = w_is_last ? '0 : w_bit_idx + CNT_W'(1);
        end else if (io_bus.clear) begin
            w_carry_nxt = 1'b0;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= 1'b0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_carry <= w_carry_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= io_bus.in_valid;
            r_last  <= w_is_last;
            if (io_bus.in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
            end
        end
    end

    assign io_bus.sum       = w_sum;
    assign io_bus.c_out     = w_cout;
    assign io_bus.sum_q     = r_sum;
    assign io_bus.c_out_q   = r_cout;
    assign io_bus.out_valid = r_valid;
    assign io_bus.word_last = r_last;

endmodule

// File: tb/tb_adder_1bit.sv
// Directed self-checking bench for adder_1bit (WIDTH=8).
module tb_adder_1bit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    adder_1bit_if bus ();

    adder_1bit #(.WIDTH(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    task automatic idle_inputs();
        bus.a = 1'b0; bus.b = 1'b0; bus.c_in = 1'b0;
        bus.in_valid = 1'b0; bus.serial_en = 1'b0; bus.clear = 1'b0;
    endtask

    // Streams one 8-bit word LSB-first, collecting registered results.
    task automatic run_word(input logic [7:0] wa, input logic [7:0] wb, input logic use_clear,
                            output logic [7:0] s, output logic cy,
                            output int last_cnt, output int last_idx);
        s = 8'h00; cy = 1'b0; last_cnt = 0; last_idx = -1;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                s[i-1] = bus.sum_q;
                if (bus.word_last) begin
                    last_cnt++;
                    last_idx = i - 1;
                    cy = bus.c_out_q;
                end
            end
            if (i < 8) begin
                bus.a = wa[i]; bus.b = wb[i]; bus.serial_en = 1'b1;
                bus.in_valid = 1'b1; bus.clear = use_clear && (i == 0);
            end else begin
                bus.in_valid = 1'b0; bus.clear = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        total++; if ({bus.sum_q, bus.c_out_q, bus.out_valid, bus.word_last} !== 4'b0000) begin
            bad++; $display("FAIL reset_outputs got=%b want=0000",
                {bus.sum_q, bus.c_out_q, bus.out_valid, bus.word_last});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_comb();
        logic [1:0] exp_tab [8];
        logic [2:0] v;
        exp_tab = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            bus.a = v[2]; bus.b = v[1]; bus.c_in = v[0];
            #20;
            total++; if ({bus.sum, bus.c_out} !== exp_tab[i]) begin
                bad++; $display("FAIL comb_%0d got=%b want=%b", i, {bus.sum, bus.c_out}, exp_tab[i]);
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        bus.a = 1'b1; bus.b = 1'b1; bus.c_in = 1'b1; bus.serial_en = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        total++; if ({bus.sum_q, bus.c_out_q, bus.out_valid, bus.word_last} !== 4'b1110) begin
            bad++; $display("FAIL reg_capture got=%b want=1110",
                {bus.sum_q, bus.c_out_q, bus.out_valid, bus.word_last});
        end
        idle_inputs();
        @(negedge clk);
        total++; if ({bus.sum_q, bus.c_out_q, bus.out_valid} !== 3'b110) begin
            bad++; $display("FAIL reg_hold got=%b want=110", {bus.sum_q, bus.c_out_q, bus.out_valid});
        end
    endtask

    task automatic test_serial();
        logic [7:0] s; logic cy; int lc; int li;
        run_word(8'hB5, 8'h6E, 1'b1, s, cy, lc, li);
        total++; if (s !== 8'h23) begin bad++; $display("FAIL serial_sum got=%h want=23", s); end
        total++; if (cy !== 1'b1) begin bad++; $display("FAIL serial_carry got=%b want=1", cy); end
        total++; if (lc !== 1 || li !== 7) begin
            bad++; $display("FAIL serial_last got=cnt%0d/idx%0d want=cnt1/idx7", lc, li);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s; logic cy; int lc; int li;
        run_word(8'hFF, 8'h01, 1'b0, s, cy, lc, li);
        total++; if ({s, cy} !== {8'h00, 1'b1}) begin
            bad++; $display("FAIL b2b_w1 got=%h/%b want=00/1", s, cy);
        end
        run_word(8'h01, 8'h01, 1'b0, s, cy, lc, li);
        total++; if ({s, cy} !== {8'h02, 1'b0}) begin
            bad++; $display("FAIL b2b_w2 got=%h/%b want=02/0", s, cy);
        end
        total++; if (lc !== 1 || li !== 7) begin
            bad++; $display("FAIL b2b_last got=cnt%0d/idx%0d want=cnt1/idx7", lc, li);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] s; logic cy; int lc; int li;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.a = 1'b1; bus.b = 1'b1; bus.serial_en = 1'b1; bus.in_valid = 1'b1;
            bus.clear = (i == 0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.clear = 1'b0;
        total++; if ({bus.c_out_q, bus.out_valid} !== 2'b11) begin
            bad++; $display("FAIL pre_reset got=%b want=11", {bus.c_out_q, bus.out_valid});
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({bus.sum_q, bus.c_out_q, bus.out_valid, bus.word_last} !== 4'b0000) begin
            bad++; $display("FAIL midword_reset got=%b want=0000",
                {bus.sum_q, bus.c_out_q, bus.out_valid, bus.word_last});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_word(8'h03, 8'h01, 1'b0, s, cy, lc, li);
        total++; if ({s, cy} !== {8'h04, 1'b0}) begin
            bad++; $display("FAIL post_reset_word got=%h/%b want=04/0", s, cy);
        end
        total++; if (lc !== 1 || li !== 7) begin
            bad++; $display("FAIL post_reset_last got=cnt%0d/idx%0d want=cnt1/idx7", lc, li);
        end
    endtask

    task automatic test_clear_with_valid();
        int li = -1;
        int lc = 0;
        @(negedge clk);
        bus.a = 1'b1; bus.b = 1'b1; bus.serial_en = 1'b1; bus.in_valid = 1'b1; bus.clear = 1'b0;
        @(negedge clk);
        bus.a = 1'b1; bus.b = 1'b0; bus.clear = 1'b1;
        #1;
        total++; if ({bus.sum, bus.c_out} !== 2'b10) begin
            bad++; $display("FAIL clear_comb got=%b want=10", {bus.sum, bus.c_out});
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                total++; if ({bus.sum_q, bus.c_out_q} !== 2'b10) begin
                    bad++; $display("FAIL clear_reg got=%b want=10", {bus.sum_q, bus.c_out_q});
                end
            end
            if (bus.word_last) begin lc++; li = i - 1; end
            bus.a = 1'b0; bus.b = 1'b0; bus.clear = 1'b0;
            bus.in_valid = (i < 8);
        end
        total++; if (lc !== 1 || li !== 7) begin
            bad++; $display("FAIL clear_restart got=cnt%0d/idx%0d want=cnt1/idx7", lc, li);
        end
    endtask

    initial begin
        test_reset();
        test_comb();
        test_registered();
        test_serial();
        test_back_to_back();
        test_async_reset();
        test_clear_with_valid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_1bit.md
# adder_1bit

Single-bit full-adder slice with a registered output stage and an optional bit-serial mode. Combinational `sum`/`c_out` serve as a building block in ripple-carry datapaths and comparators. In serial mode the block adds two WIDTH-bit words LSB-first, one bit per valid cycle, using an internal carry register.

## Interface
- WIDTH, 8: serial word length in bits (≥1); sets bit-counter wrap and `word_last`.
- clk  in  1  rising-edge clock for all registers.
- rst_n  in  1  reset, asynchronous and active-low; one clock.
- a  in  1  operand bit A.
- b  in  1  operand bit B.
- c_in  in  1  external carry-in; used only when `serial_en`=0.
- in_valid  in  1  qualifies a/b/c_in for the registered path and serial state.
- serial_en  in  1  1: carry-in taken from internal carry register; 0: from `c_in`.
- clear  in  1  synchronous word restart: forces effective carry-in 0 this cycle, resets bit counter.
- sum  out  1  combinational sum, a ^ b ^ cin_eff.
- c_out  out  1  combinational carry-out, majority(a, b, cin_eff).
- sum_q  out  1  registered `sum`.
- c_out_q  out  1  registered `c_out`.
- out_valid  out  1  registered `in_valid`.
- word_last  out  1  with `out_valid`, marks result of serial bit WIDTH-1.

## Operation
- cin_eff = clear ? 0 : (serial_en ? carry_q : c_in).
- `sum`/`c_out` are pure combinational functions of a, b, cin_eff; valid regardless of `in_valid`, clock or reset.
- On a cycle with `in_valid`=1: sum_q←sum, c_out_q←c_out, out_valid←1. With `in_valid`=0: out_valid←0, sum_q/c_out_q hold.
- Carry register: on `in_valid`=1 and `serial_en`=1, carry_q←c_out. On `clear`=1 without `in_valid`, carry_q←0. When `serial_en`=0, carry_q←0.
- Bit counter (0..WIDTH-1): increments on each `in_valid`&`serial_en` cycle. At WIDTH-1, it wraps to 0 and carry_q←0; this auto-clears carry for the next word.
- `clear` resets the counter to 0. With simultaneous `in_valid`, that bit is processed as bit 0 and the counter advances to 1.
- word_last←1 registered alongside the bit processed at count WIDTH-1 in serial mode; otherwise 0.
- Final serial carry-out of a word is `c_out_q` while `word_last`=1.
- Dropping `serial_en` mid-word resets the counter and carry_q to 0.

## Timing
- Combinational path: 0-cycle latency.
- Registered path: 1-cycle latency; out_valid follows in_valid by exactly one cycle; full throughput, one bit per cycle.
- Reset (rst_n=0, immediate): sum_q=0, c_out_q=0, out_valid=0, word_last=0, carry_q=0, counter=0.
- Reset mid-word aborts the word; the first valid bit after release is bit 0 with carry 0.
- `clear` takes priority over carry_q and the counter.
- Gaps (`in_valid`=0) inside a serial word are allowed; state holds.

## Structure
- No shared package contents beyond a common WIDTH default constant, if the team package defines one.
- Natural sub-module: `full_adder_cell`, a purely combinational cell (a, b, cin → sum, cout).
- The top wraps the cell with carry mux, carry register, bit counter and output registers.

## Test plan
- Exhaustive combinational, serial_en=0: {a,b,c_in}=000..111 held 20 ns each. Required {sum,c_out}: 000→0,0; 001→1,0; 010→1,0; 011→0,1; 100→1,0; 101→0,1; 110→0,1; 111→1,1.
- Registered path: in_valid pulse with a=1,b=1,c_in=1. Next cycle sum_q=1, c_out_q=1, out_valid=1; the following cycle out_valid=0 and values hold.
- Serial add, WIDTH=8: clear on first bit, 0xB5+0x6E LSB-first. Collected sum_q bits=0x23; word_last on 8th result with c_out_q=1.
- Back-to-back words without clear: 0xFF+0x01 then 0x01+0x01. First word gives sum 0x00, carry 1. Second gives 0x02, carry 0, proving the auto-clear.
- Async reset mid-word after 3 bits: outputs go to 0 immediately. The next word 0x03+0x01 gives 0x04 with correct word_last timing.
- Clear with in_valid while carry_q=1: bit result uses carry-in 0 (a=1,b=0 → sum=1, c_out=0); the counter restarts.
